ddr3_ddl_arb: RTL and testbench

Shares the single DDL command port and its READ-data return path between two requesters: port A (main memory-controller FSM) and port B (fast-read bypass path). Grants whole command sequences (e.g. ACT->RD->PRE) atomically and round-robins between the ports. Gives port A exclusive access while a refresh is due. Tags every issued READ with its owner, so returned read bursts are steered back to the correct port in order.

---
 rtl/ddr3_pkg.sv | 28 ++
 rtl/ddr3_tag_fifo.sv | 71 +++++++
 rtl/ddr3_ddl_arb.sv | 198 +++++++++++++++++++
 tb/tb_ddr3_ddl_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// ddr3_pkg: shared definitions for the DDL command-port arbiter.
//   - DDR3 command encodings as {ras_n, cas_n, we_n}
//   - arbiter state encodings
//   - owner tag encoding for outstanding READ bursts
//   - small helper to recognise a READ command
package ddr3_pkg;

    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_A = 2'd1;
    localparam logic [1:0] ST_GNT_B = 2'd2;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/ddr3_tag_fifo.sv
// ddr3_tag_fifo: 1-bit wide synchronous FIFO holding the owner of each
// outstanding READ burst.
//   clock, reset   : system clock, synchronous active-high reset
//   push_i         : write push_tag_i (ignored when full)
//   push_tag_i     : owner bit (0 = port A, 1 = port B)
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : owner bit at the head of the FIFO
//   full_o/empty_o : occupancy flags
// Push and pop in the same cycle leave the occupancy unchanged.
module ddr3_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  logic push_tag_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_MAX);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= push_tag_i;
    end

endmodule

// File: rtl/ddr3_ddl_arb.sv
// ddr3_ddl_arb: shares the DDL command port and its READ-data return path
// between port A (main controller FSM) and port B (fast-read bypass).
//   clock, reset             : system clock, synchronous active-high reset
//   ddl_run_i                : DDL ready for traffic; no grants while low
//   ref_due_i                : refresh pending; only port A may be granted
//   {a,b}_req/seq/cmd/ba/adr : per-port command request and sequence hold
//   {a,b}_rdy_o              : per-port command accept
//   {a,b}_ref_o              : ref_due_i registered once
//   ddl_req/seq/cmd/ba/adr_o : muxed command to the DDL, ddl_rdy_i accept
//   ddl_rvalid/rlast/rdata_i : READ data from the DDL, ddl_rready_o backpressure
//   {a,b}_rvalid/rlast/rdata_o, {a,b}_rready_i : steered READ data per port
// Whole command sequences are granted atomically (seq=1 holds the grant),
// ports alternate on contention, and every issued READ is tagged with its
// owner so read bursts are returned to the right port in order.
module ddr3_ddl_arb
    import ddr3_pkg::*;
#(
    parameter int DDR_ROW_BITS = 15,
    parameter int WIDTH        = 32,
    parameter int TAG_DEPTH    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ddl_run_i,
    input  logic                    ref_due_i,

    input  logic                    a_req_i,
    input  logic                    a_seq_i,
    output logic                    a_rdy_o,
    input  logic [2:0]              a_cmd_i,
    input  logic [2:0]              a_ba_i,
    input  logic [DDR_ROW_BITS-1:0] a_adr_i,
    output logic                    a_ref_o,

    input  logic                    b_req_i,
    input  logic                    b_seq_i,
    output logic                    b_rdy_o,
    input  logic [2:0]              b_cmd_i,
    input  logic [2:0]              b_ba_i,
    input  logic [DDR_ROW_BITS-1:0] b_adr_i,
    output logic                    b_ref_o,

    output logic                    ddl_req_o,
    output logic                    ddl_seq_o,
    input  logic                    ddl_rdy_i,
    output logic [2:0]              ddl_cmd_o,
    output logic [2:0]              ddl_ba_o,
    output logic [DDR_ROW_BITS-1:0] ddl_adr_o,

    input  logic                    ddl_rvalid_i,
    input  logic                    ddl_rlast_i,
    output logic                    ddl_rready_o,
    input  logic [WIDTH-1:0]        ddl_rdata_i,

    output logic                    a_rvalid_o,
    output logic                    a_rlast_o,
    input  logic                    a_rready_i,
    output logic [WIDTH-1:0]        a_rdata_o,

    output logic                    b_rvalid_o,
    output logic                    b_rlast_o,
    input  logic                    b_rready_i,
    output logic [WIDTH-1:0]        b_rdata_o
);

    logic [1:0] state_q, state_d;
    logic       last_b_q, last_b_d;   // 1: port B was served last
    logic       ref_q;

    logic       tag_full, tag_empty, tag_head;
    logic       tag_push, tag_push_own, tag_pop;

    logic       xfer, xfer_seq;
    logic       read_blocked;

    // Command path: passthrough of the granted port, everything else idle.
    always_comb begin
        ddl_req_o    = 1'b0;
        ddl_seq_o    = 1'b0;
        ddl_cmd_o    = CMD_NOP;
        ddl_ba_o     = '0;
        ddl_adr_o    = '0;
        a_rdy_o      = 1'b0;
        b_rdy_o      = 1'b0;
        read_blocked = 1'b0;
        xfer         = 1'b0;
        xfer_seq     = 1'b0;
        tag_push     = 1'b0;
        tag_push_own = OWN_A;
        case (state_q)
            ST_GNT_A: begin
                // A READ with no free tag slot must neither be accepted
                // nor presented to the DDL.
                read_blocked = is_read(a_cmd_i) & tag_full;
                a_rdy_o      = ddl_rdy_i & ~read_blocked;
                ddl_req_o    = a_req_i & ~read_blocked;
                ddl_seq_o    = a_seq_i;
                ddl_cmd_o    = a_cmd_i;
                ddl_ba_o     = a_ba_i;
                ddl_adr_o    = a_adr_i;
                xfer         = a_req_i & a_rdy_o;
                xfer_seq     = a_seq_i;
                tag_push     = xfer & is_read(a_cmd_i);
                tag_push_own = OWN_A;
            end
            ST_GNT_B: begin
                read_blocked = is_read(b_cmd_i) & tag_full;
                b_rdy_o      = ddl_rdy_i & ~read_blocked;
                ddl_req_o    = b_req_i & ~read_blocked;
                ddl_seq_o    = b_seq_i;
                ddl_cmd_o    = b_cmd_i;
                ddl_ba_o     = b_ba_i;
                ddl_adr_o    = b_adr_i;
                xfer         = b_req_i & b_rdy_o;
                xfer_seq     = b_seq_i;
                tag_push     = xfer & is_read(b_cmd_i);
                tag_push_own = OWN_B;
            end
            default: ;
        endcase
    end

    // Grant decision. IDLE never drives a grant; the decision is registered.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        case (state_q)
            ST_IDLE: begin
                if (ddl_run_i) begin
                    if (ref_due_i) begin
                        // Refresh pending: only the controller port may run.
                        if (a_req_i) state_d = ST_GNT_A;
                    end else if (a_req_i && b_req_i) begin
                        state_d = last_b_q ? ST_GNT_A : ST_GNT_B;
                    end else if (a_req_i) begin
                        state_d = ST_GNT_A;
                    end else if (b_req_i) begin
                        state_d = ST_GNT_B;
                    end
                end
            end
            ST_GNT_A: begin
                if (xfer && !xfer_seq) begin
                    state_d  = ST_IDLE;
                    last_b_d = 1'b0;
                end
            end
            ST_GNT_B: begin
                if (xfer && !xfer_seq) begin
                    state_d  = ST_IDLE;
                    last_b_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_b_q <= 1'b1;
            ref_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            ref_q    <= ref_due_i;
        end
    end

    assign a_ref_o = ref_q;
    assign b_ref_o = ref_q;

    // Read steering: the FIFO head names the owner of the burst in flight.
    // With no outstanding READ the data is stalled rather than misrouted.
    assign a_rvalid_o   = ddl_rvalid_i & ~tag_empty & (tag_head == OWN_A);
    assign b_rvalid_o   = ddl_rvalid_i & ~tag_empty & (tag_head == OWN_B);
    assign a_rlast_o    = ddl_rlast_i & a_rvalid_o;
    assign b_rlast_o    = ddl_rlast_i & b_rvalid_o;
    assign ddl_rready_o = ~tag_empty & ((tag_head == OWN_B) ? b_rready_i : a_rready_i);
    assign a_rdata_o    = ddl_rdata_i;
    assign b_rdata_o    = ddl_rdata_i;

    assign tag_pop = ddl_rvalid_i & ddl_rlast_i & ddl_rready_o;

    ddr3_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (tag_push),
        .push_tag_i (tag_push_own),
        .pop_i      (tag_pop),
        .head_o     (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

endmodule

// File: tb/tb_ddr3_ddl_arb.sv
// Bench for ddr3_ddl_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_ddr3_ddl_arb;

    localparam int RB = 15;
    localparam int W  = 32;
    localparam int TD = 8;

    localparam logic [2:0] NOP = 3'b111, RD = 3'b101, WR = 3'b100,
                           ACT = 3'b011, PRE = 3'b010, REF = 3'b001;

    logic          clock = 1'b0;
    logic          reset, ddl_run, ref_due;
    logic          a_req, a_seq, b_req, b_seq;
    logic [2:0]    a_cmd, a_ba, b_cmd, b_ba;
    logic [RB-1:0] a_adr, b_adr;
    logic          ddl_rdy, ddl_rvalid, ddl_rlast, a_rready, b_rready;
    logic [W-1:0]  ddl_rdata;

    logic          a_rdy, b_rdy, a_ref, b_ref, ddl_req, ddl_seq, ddl_rready;
    logic [2:0]    ddl_cmd, ddl_ba;
    logic [RB-1:0] ddl_adr;
    logic          a_rvalid, a_rlast, b_rvalid, b_rlast;
    logic [W-1:0]  a_rdata, b_rdata;

    int vectors = 0;
    int fails   = 0;

    always #5 clock = ~clock;

    ddr3_ddl_arb #(.DDR_ROW_BITS(RB), .WIDTH(W), .TAG_DEPTH(TD)) dut (
        .clock(clock), .reset(reset), .ddl_run_i(ddl_run), .ref_due_i(ref_due),
        .a_req_i(a_req), .a_seq_i(a_seq), .a_rdy_o(a_rdy), .a_cmd_i(a_cmd),
        .a_ba_i(a_ba), .a_adr_i(a_adr), .a_ref_o(a_ref),
        .b_req_i(b_req), .b_seq_i(b_seq), .b_rdy_o(b_rdy), .b_cmd_i(b_cmd),
        .b_ba_i(b_ba), .b_adr_i(b_adr), .b_ref_o(b_ref),
        .ddl_req_o(ddl_req), .ddl_seq_o(ddl_seq), .ddl_rdy_i(ddl_rdy),
        .ddl_cmd_o(ddl_cmd), .ddl_ba_o(ddl_ba), .ddl_adr_o(ddl_adr),
        .ddl_rvalid_i(ddl_rvalid), .ddl_rlast_i(ddl_rlast), .ddl_rready_o(ddl_rready),
        .ddl_rdata_i(ddl_rdata),
        .a_rvalid_o(a_rvalid), .a_rlast_o(a_rlast), .a_rready_i(a_rready), .a_rdata_o(a_rdata),
        .b_rvalid_o(b_rvalid), .b_rlast_o(b_rlast), .b_rready_i(b_rready), .b_rdata_o(b_rdata)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 none, 1 port A, 2 port B
    int  m_owner  = 0;
    bit  m_last_b = 1'b1;
    bit  m_ref    = 1'b0;
    bit  m_valid  = 1'b0;
    bit  tagq[$];

    logic          e_a_rdy, e_b_rdy, e_req, e_seq, e_rready;
    logic          e_a_rvalid, e_b_rvalid, e_a_rlast, e_b_rlast, e_push;
    logic [2:0]    e_cmd, e_ba;
    logic [RB-1:0] e_adr;

    function automatic void compute_exp();
        logic full, blk, head;
        full = (tagq.size() == TD);
        e_a_rdy = 0; e_b_rdy = 0; e_req = 0; e_seq = 0; e_push = 0;
        e_cmd = NOP; e_ba = 0; e_adr = 0;
        if (m_owner == 1) begin
            blk = (a_cmd == RD) && full;
            e_a_rdy = ddl_rdy && !blk;
            e_req = a_req && !blk; e_seq = a_seq;
            e_cmd = a_cmd; e_ba = a_ba; e_adr = a_adr;
            e_push = a_req && e_a_rdy && (a_cmd == RD);
        end else if (m_owner == 2) begin
            blk = (b_cmd == RD) && full;
            e_b_rdy = ddl_rdy && !blk;
            e_req = b_req && !blk; e_seq = b_seq;
            e_cmd = b_cmd; e_ba = b_ba; e_adr = b_adr;
            e_push = b_req && e_b_rdy && (b_cmd == RD);
        end
        if (tagq.size() == 0) begin
            e_a_rvalid = 0; e_b_rvalid = 0; e_rready = 0;
        end else begin
            head = tagq[0];
            e_a_rvalid = ddl_rvalid && !head;
            e_b_rvalid = ddl_rvalid && head;
            e_rready   = head ? b_rready : a_rready;
        end
        e_a_rlast = e_a_rvalid && ddl_rlast;
        e_b_rlast = e_b_rvalid && ddl_rlast;
    endfunction

    always @(posedge clock) begin
        bit pop, xfer, xseq;
        compute_exp();
        if (reset) begin
            m_owner = 0; m_last_b = 1; m_ref = 0; tagq.delete();
            m_valid = 1;
        end else if (m_valid) begin
            pop = ddl_rvalid && ddl_rlast && e_rready;
            if (pop) void'(tagq.pop_front());
            if (e_push) tagq.push_back(m_owner == 2);
            m_ref = ref_due;
            if (m_owner == 0) begin
                if (ddl_run) begin
                    if (ref_due)            m_owner = a_req ? 1 : 0;
                    else if (a_req && b_req) m_owner = m_last_b ? 1 : 2;
                    else if (a_req)          m_owner = 1;
                    else if (b_req)          m_owner = 2;
                end
            end else begin
                xfer = (m_owner == 1) ? (a_req && e_a_rdy) : (b_req && e_b_rdy);
                xseq = (m_owner == 1) ? a_seq : b_seq;
                if (xfer && !xseq) begin
                    m_last_b = (m_owner == 2);
                    m_owner  = 0;
                end
            end
        end
    end

    // Compare process: every cycle once the model is anchored by reset.
    always @(negedge clock) begin
        if (m_valid) begin
            compute_exp();
            cmp("a_rdy", a_rdy, e_a_rdy);
            cmp("b_rdy", b_rdy, e_b_rdy);
            cmp("ddl_req", ddl_req, e_req);
            cmp("ddl_seq", ddl_seq, e_seq);
            cmp("ddl_cmd", ddl_cmd, e_cmd);
            cmp("ddl_ba", ddl_ba, e_ba);
            cmp("ddl_adr", ddl_adr, e_adr);
            cmp("ddl_rready", ddl_rready, e_rready);
            cmp("a_rvalid", a_rvalid, e_a_rvalid);
            cmp("b_rvalid", b_rvalid, e_b_rvalid);
            cmp("a_rlast", a_rlast, e_a_rlast);
            cmp("b_rlast", b_rlast, e_b_rlast);
            cmp("a_ref", a_ref, m_ref);
            cmp("b_ref", b_ref, m_ref);
            cmp("a_rdata", a_rdata, ddl_rdata);
            cmp("b_rdata", b_rdata, ddl_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic go();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ddl_run = 1; ref_due = 0;
        a_req = 0; a_seq = 0; a_cmd = NOP; a_ba = 0; a_adr = 0;
        b_req = 0; b_seq = 0; b_cmd = NOP; b_ba = 0; b_adr = 0;
        ddl_rdy = 1; ddl_rvalid = 0; ddl_rlast = 0; a_rready = 0; b_rready = 0;
        ddl_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        go(); go();
        reset = 0;
    endtask

    initial begin
        logic [2:0] cmds [6];
        cmds[0] = NOP; cmds[1] = RD; cmds[2] = WR; cmds[3] = ACT; cmds[4] = PRE; cmds[5] = REF;
        idle_inputs();
        do_reset();
        #2;
        cmp("rst_cmd", ddl_cmd, NOP);
        cmp("rst_req", ddl_req, 0);
        cmp("rst_arddy", a_rdy, 0);

        // Round robin from reset: A, B, A with single-command sequences.
        a_req = 1; a_cmd = ACT; b_req = 1; b_cmd = ACT; #2;
        cmp("rr_idle_a", a_rdy, 0);
        go(); #2; cmp("rr1_a", a_rdy, 1); cmp("rr1_b", b_rdy, 0);
        go(); #2; cmp("rr2_idle", ddl_req, 0);
        go(); #2; cmp("rr3_b", b_rdy, 1); cmp("rr3_a", a_rdy, 0);
        go(); go(); #2; cmp("rr5_a", a_rdy, 1);
        go(); a_req = 0; b_req = 0;

        // A-only ACT, RD, PRE sequence.
        go();
        a_req = 1; a_cmd = ACT; a_seq = 1; #2;
        cmp("seq_idle", a_rdy, 0);
        go(); #2; cmp("seq_act", ddl_cmd, ACT); cmp("seq_act_rdy", a_rdy, 1);
        go(); a_cmd = RD;  #2; cmp("seq_rd", ddl_cmd, RD);
        go(); a_cmd = PRE; a_seq = 0; #2; cmp("seq_pre", ddl_cmd, PRE);
        go(); a_req = 0; ddl_rvalid = 1; ddl_rlast = 1; a_rready = 1; #2;
        cmp("seq_back_idle", ddl_cmd, NOP);
        cmp("seq_tag_a", a_rvalid, 1);
        cmp("seq_tag_b", b_rvalid, 0);
        cmp("seq_rready", ddl_rready, 1);
        go(); ddl_rvalid = 0; ddl_rlast = 0; a_rready = 0; #2;
        cmp("seq_fifo_empty", ddl_rready, 0);

        // Fill the tag FIFO, block the 9th READ, let a WRITE through.
        go(); a_req = 1; a_cmd = RD; a_seq = 1;
        go();
        for (int i = 0; i < TD; i++) go();
        #2; cmp("full_rd_rdy", a_rdy, 0); cmp("full_rd_req", ddl_req, 0);
        go(); a_cmd = WR; #2; cmp("full_wr_rdy", a_rdy, 1);
        go(); a_cmd = RD; ddl_rvalid = 1; ddl_rlast = 1; a_rready = 1; #2;
        cmp("full_pop_rdy", a_rdy, 0); cmp("full_pop_rready", ddl_rready, 1);
        go(); ddl_rvalid = 0; ddl_rlast = 0; a_rready = 0; #2;
        cmp("after_pop_rdy", a_rdy, 1);
        go(); a_cmd = PRE; a_seq = 0;
        go(); a_req = 0;

        // Refresh due: B locked out, A's REF granted, B follows.
        ref_due = 1; b_req = 1; b_cmd = ACT; b_seq = 0;
        for (int i = 0; i < 4; i++) begin
            go(); #2; cmp("ref_b_blocked", b_rdy, 0);
        end
        a_req = 1; a_cmd = REF; a_seq = 0; #2; cmp("ref_a_idle", a_rdy, 0);
        go(); ref_due = 0; #2; cmp("ref_a_gnt", a_rdy, 1); cmp("ref_o_hi", a_ref, 1);
        go(); a_req = 0; #2; cmp("ref_b_wait", b_rdy, 0); cmp("ref_o_lo", b_ref, 0);
        go(); #2; cmp("ref_b_gnt", b_rdy, 1);
        go(); b_req = 0;

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            go();
            reset      = ($urandom_range(0, 199) == 0);
            ddl_run    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) ref_due = ~ref_due;
            a_req      = ($urandom_range(0, 3) != 0);
            b_req      = ($urandom_range(0, 3) != 0);
            a_seq      = $urandom_range(0, 1);
            b_seq      = $urandom_range(0, 1);
            a_cmd      = ($urandom_range(0, 9) < 4) ? RD : cmds[$urandom_range(0, 5)];
            b_cmd      = ($urandom_range(0, 9) < 4) ? RD : cmds[$urandom_range(0, 5)];
            a_ba       = 3'($urandom);
            b_ba       = 3'($urandom);
            a_adr      = RB'($urandom);
            b_adr      = RB'($urandom);
            ddl_rdy    = ($urandom_range(0, 3) != 0);
            ddl_rvalid = $urandom_range(0, 1);
            ddl_rlast  = ($urandom_range(0, 9) < 4);
            a_rready   = ($urandom_range(0, 9) < 7);
            b_rready   = ($urandom_range(0, 9) < 7);
            ddl_rdata  = $urandom;
        end

        // Reset with read data still arriving: everything returns to idle.
        go(); reset = 1; ddl_rvalid = 1; ddl_rlast = 1; a_rready = 1; b_rready = 1;
        a_req = 0; b_req = 0; ddl_run = 0;
        go(); reset = 0; #2;
        cmp("post_rst_cmd", ddl_cmd, NOP);
        cmp("post_rst_arv", a_rvalid, 0);
        cmp("post_rst_brv", b_rvalid, 0);
        cmp("post_rst_rready", ddl_rready, 0);
        cmp("post_rst_ref", a_ref, 0);
        go(); go();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
